// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, FSM states and decode helpers shared by the MDU and the hazard logic.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU as multiply-class operations.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // Ops that occupy the unit; the hazard unit stalls on busy | (start & is_md_op(op)).
  function automatic logic is_md_op(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit result for multiply, divide and multiply-accumulate.
// Result layout is {HI, LO}; div_zero flags a DIV/DIVU whose divisor is zero.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // NOTE: every variable gets a default before any branch so no path infers a latch.
  always_comb begin
    sgn      = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    a_ext    = {{32{sgn & a[31]}}, a};
    b_ext    = {{32{sgn & b[31]}}, b};
    prod     = a_ext * b_ext;
    div_zero = is_div_op(op) && (b == 32'd0);

    // Divide magnitudes, then fix signs: avoids the 0x80000000 / -1 overflow case.
    a_mag = (sgn && a[31]) ? -a : a;
    b_mag = (sgn && b[31]) ? -b : b;
    q_mag = div_zero ? 32'd0 : a_mag / b_mag;
    r_mag = div_zero ? 32'd0 : a_mag % b_mag;
    quo   = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem   = (sgn && a[31]) ? -r_mag : r_mag;

    result = prod;
    case (op)
      OP_DIV, OP_DIVU:   result = {rem, quo};
      OP_MADD, OP_MADDU: result = acc + prod;
      OP_MSUB, OP_MSUBU: result = acc - prod;
      default:           result = prod;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MIPS multiply/divide unit holding HI/LO, busy for a fixed latency.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [31:0]       a_q, b_q;
  logic [63:0]       result;
  logic              div_zero;

  // Operands are staged at issue; the accumulator input is live HI/LO, read at commit.
  mdu_calc u_calc (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .acc     ({hi, lo}),
    .result  (result),
    .div_zero(div_zero)
  );

  assign rd_data = (op == OP_MFLO) ? lo : hi;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (is_mul_op(op)) begin
                state <= ST_MUL;
                cnt   <= CNT_W'(MULT_CYCLES - 1);
                busy  <= 1'b1;
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
              end else if (is_div_op(op)) begin
                state <= ST_DIV;
                cnt   <= CNT_W'(DIV_CYCLES - 1);
                busy  <= 1'b1;
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
              end else if (op == OP_MTHI) begin
                hi <= src_a;
              end else if (op == OP_MTLO) begin
                lo <= src_a;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // A zero divisor still takes the full latency but leaves HI/LO alone.
              if (!div_zero) begin
                hi <= result[63:32];
                lo <= result[31:0];
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
